out_port_arbiter: RTL and testbench

//  Per-output-port arbiter between the four routing blocks and one out_buffer FIFO.

---
 rtl/out_port_arbiter_pkg.sv | 21 ++
 rtl/out_port_arbiter_rr_picker.sv | 42 ++++
 rtl/out_port_arbiter.sv | 119 +++++++++++
 tb/tb_out_port_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/out_port_arbiter_pkg.sv
// Shared types for the per-output-port arbiter.
// Packet layout and router-wide port count.
package out_port_arbiter_pkg;

    localparam int NUM_PORTS = 4;
    localparam int PKT_W     = 32;

    typedef struct packed {
        logic [7:0]  src_id;
        logic [7:0]  dest_id;
        logic [15:0] data;
    } pkt_t;

    typedef enum logic [1:0] {
        SRC_N = 2'd0,
        SRC_E = 2'd1,
        SRC_S = 2'd2,
        SRC_W = 2'd3
    } src_e;

endpackage

// File: rtl/out_port_arbiter_rr_picker.sv
// Round-robin picker: first request at or after ptr,
// falling back to the lowest request when none lies at or above ptr.
module out_port_arbiter_rr_picker #(
    parameter int NUM_IN = 4,
    parameter int IDX_W  = 2
) (
    input  logic [NUM_IN-1:0] req_i,
    input  logic [IDX_W-1:0]  ptr_i,
    output logic [NUM_IN-1:0] win_o,
    output logic [IDX_W-1:0]  win_idx_o,
    output logic              any_o
);

    logic [NUM_IN-1:0] mask;
    logic [NUM_IN-1:0] masked;
    logic [NUM_IN-1:0] sel;
    logic              found;

    // Mask off requests below ptr, then take the lowest surviving bit.
    always_comb begin
        mask      = '0;
        win_o     = '0;
        win_idx_o = '0;
        found     = 1'b0;
        for (int i = 0; i < NUM_IN; i++) begin
            mask[i] = (IDX_W'(i) >= ptr_i);
        end
        masked = req_i & mask;
        sel    = (|masked) ? masked : req_i;
        any_o  = |req_i;
        for (int i = 0; i < NUM_IN; i++) begin
            if (sel[i] && !found) begin
                win_idx_o = IDX_W'(i);
                found     = 1'b1;
            end
        end
        if (any_o) begin
            win_o[win_idx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/out_port_arbiter.sv
// Output-port arbiter: round-robin among routing sources into a
// one-entry output register. Optional grant counters under ARB_STATS_EN.
module out_port_arbiter
    import out_port_arbiter_pkg::*;
#(
    parameter int NUM_IN = NUM_PORTS
`ifdef ARB_STATS_EN
    ,
    parameter int CNT_W  = 16
`endif
) (
    input  logic                  clk,
    input  logic                  rst_b,
    input  logic [NUM_IN-1:0]     req_valid,
    input  pkt_t [NUM_IN-1:0]     req_pkt,
    output logic [NUM_IN-1:0]     grant,
    output pkt_t                  out_pkt,
    output logic                  out_valid,
    input  logic                  out_ready
`ifdef ARB_STATS_EN
    ,
    output logic [NUM_IN-1:0][CNT_W-1:0] grant_count
`endif
);

    localparam int IDX_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

    logic [IDX_W-1:0]  rr_ptr_q;
    logic [IDX_W-1:0]  rr_ptr_d;
    pkt_t              out_pkt_q;
    pkt_t              out_pkt_d;
    logic              out_valid_q;
    logic              out_valid_d;

    logic [NUM_IN-1:0] win;
    logic [IDX_W-1:0]  win_idx;
    logic              any_req;
    logic              can_accept;
    logic              grant_en;

    out_port_arbiter_rr_picker #(
        .NUM_IN (NUM_IN),
        .IDX_W  (IDX_W)
    ) u_picker (
        .req_i     (req_valid),
        .ptr_i     (rr_ptr_q),
        .win_o     (win),
        .win_idx_o (win_idx),
        .any_o     (any_req)
    );

    // Slot is free if empty or draining this cycle; no grant while in reset.
    always_comb begin
        can_accept = ~out_valid_q | out_ready;
        grant_en   = can_accept & any_req & rst_b;
        grant      = grant_en ? win : '0;
    end

    // Next state of the output register and round-robin pointer.
    always_comb begin
        out_pkt_d   = out_pkt_q;
        out_valid_d = out_valid_q;
        rr_ptr_d    = rr_ptr_q;
        if (grant_en) begin
            out_pkt_d   = req_pkt[win_idx];
            out_valid_d = 1'b1;
            if (win_idx == IDX_W'(NUM_IN - 1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = win_idx + 1'b1;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Output register and pointer state.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            out_pkt_q   <= '0;
            out_valid_q <= 1'b0;
            rr_ptr_q    <= '0;
        end else begin
            out_pkt_q   <= out_pkt_d;
            out_valid_q <= out_valid_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_pkt   = out_pkt_q;
    assign out_valid = out_valid_q;

`ifdef ARB_STATS_EN
    logic [NUM_IN-1:0][CNT_W-1:0] cnt_q;
    logic [NUM_IN-1:0][CNT_W-1:0] cnt_d;

    // Saturating per-source grant totals.
    always_comb begin
        cnt_d = cnt_q;
        for (int i = 0; i < NUM_IN; i++) begin
            if (grant[i] && (cnt_q[i] != {CNT_W{1'b1}})) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    // Counter state.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign grant_count = cnt_q;
`endif

endmodule

// File: tb/tb_out_port_arbiter.sv
// Directed bench for out_port_arbiter.
// Covers ARB_STATS_EN counters when that macro is defined.
module tb_out_port_arbiter;
    import out_port_arbiter_pkg::*;

    localparam logic [31:0] P0 = 32'h1100_0000;
    localparam logic [31:0] P1 = 32'h2200_0001;
    localparam logic [31:0] P2 = 32'h3300_0002;
    localparam logic [31:0] P3 = 32'h4400_0003;

    logic       clk = 1'b0;
    logic       rst_b;
    logic [3:0] req_valid;
    pkt_t [3:0] req_pkt;
    logic [3:0] grant;
    pkt_t       out_pkt;
    logic       out_valid;
    logic       out_ready;
`ifdef ARB_STATS_EN
    logic [3:0][3:0] grant_count;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    out_port_arbiter #(
        .NUM_IN (4)
`ifdef ARB_STATS_EN
        ,
        .CNT_W  (4)
`endif
    ) dut (
        .clk       (clk),
        .rst_b     (rst_b),
        .req_valid (req_valid),
        .req_pkt   (req_pkt),
        .grant     (grant),
        .out_pkt   (out_pkt),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef ARB_STATS_EN
        ,
        .grant_count (grant_count)
`endif
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_pkts;
        req_pkt[0] = P0;
        req_pkt[1] = P1;
        req_pkt[2] = P2;
        req_pkt[3] = P3;
    endtask

    task automatic apply_reset;
        req_valid = 4'b0000;
        out_ready = 1'b1;
        rst_b     = 1'b0;
        tick();
        rst_b = 1'b1;
    endtask

    task automatic test_reset;
        set_pkts();
        out_ready = 1'b1;
        req_valid = 4'b1111;
        rst_b     = 1'b1;
        #2;
        rst_b = 1'b0;
        #2;
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_valid got=%b exp=0", out_valid);
        end
        total++;
        if (out_pkt !== 32'h0) begin
            bad++;
            $display("FAIL reset_pkt got=%h exp=0", out_pkt);
        end
        total++;
        if (grant !== 4'b0000) begin
            bad++;
            $display("FAIL reset_grant got=%b exp=0000", grant);
        end
        tick();
        req_valid = 4'b0000;
        rst_b     = 1'b1;
        tick();
    endtask

    task automatic test_single;
        apply_reset();
        req_pkt[2] = 32'hA500_0001;
        req_valid  = 4'b0100;
        #1;
        total++;
        if (grant !== 4'b0100) begin
            bad++;
            $display("FAIL single_grant got=%b exp=0100", grant);
        end
        tick();
        req_valid = 4'b0000;
        #1;
        total++;
        if ({out_valid, out_pkt} !== {1'b1, 32'hA500_0001}) begin
            bad++;
            $display("FAIL single_out got=%b/%h exp=1/a5000001",
                     out_valid, out_pkt);
        end
        total++;
        if (grant !== 4'b0000) begin
            bad++;
            $display("FAIL single_idle_grant got=%b exp=0000", grant);
        end
        tick();
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL single_drain got=%b exp=0", out_valid);
        end
        set_pkts();
    endtask

    task automatic test_all_four;
        logic [3:0]  eg [5];
        logic [31:0] ep [5];
        eg = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        ep = '{P0, P1, P2, P3, P0};
        apply_reset();
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            #1;
            total++;
            if (grant !== eg[k]) begin
                bad++;
                $display("FAIL rr_grant%0d got=%b exp=%b", k, grant, eg[k]);
            end
            tick();
            total++;
            if ({out_valid, out_pkt} !== {1'b1, ep[k]}) begin
                bad++;
                $display("FAIL rr_out%0d got=%b/%h exp=1/%h",
                         k, out_valid, out_pkt, ep[k]);
            end
        end
        req_valid = 4'b0000;
        tick();
    endtask

    task automatic test_backpressure;
        apply_reset();
        req_valid = 4'b1000;
        #1;
        total++;
        if (grant !== 4'b1000) begin
            bad++;
            $display("FAIL bp_first_grant got=%b exp=1000", grant);
        end
        tick();
        out_ready = 1'b0;
        req_valid = 4'b0011;
        for (int k = 0; k < 5; k++) begin
            #1;
            total++;
            if (grant !== 4'b0000) begin
                bad++;
                $display("FAIL bp_grant%0d got=%b exp=0000", k, grant);
            end
            tick();
            total++;
            if ({out_valid, out_pkt} !== {1'b1, P3}) begin
                bad++;
                $display("FAIL bp_hold%0d got=%b/%h exp=1/%h",
                         k, out_valid, out_pkt, P3);
            end
        end
        out_ready = 1'b1;
        #1;
        total++;
        if (grant !== 4'b0001) begin
            bad++;
            $display("FAIL bp_release_grant got=%b exp=0001", grant);
        end
        tick();
        total++;
        if ({out_valid, out_pkt} !== {1'b1, P0}) begin
            bad++;
            $display("FAIL bp_release_out got=%b/%h exp=1/%h",
                     out_valid, out_pkt, P0);
        end
    endtask

    task automatic test_wrap;
        req_valid = 4'b0010;
        #1;
        total++;
        if (grant !== 4'b0010) begin
            bad++;
            $display("FAIL wrap_setup got=%b exp=0010", grant);
        end
        tick();
        req_valid = 4'b0011;
        #1;
        total++;
        if (grant !== 4'b0001) begin
            bad++;
            $display("FAIL wrap_grant got=%b exp=0001", grant);
        end
        tick();
        #1;
        total++;
        if (grant !== 4'b0010) begin
            bad++;
            $display("FAIL wrap_ptr1 got=%b exp=0010", grant);
        end
        tick();
        total++;
        if ({out_valid, out_pkt} !== {1'b1, P1}) begin
            bad++;
            $display("FAIL wrap_out got=%b/%h exp=1/%h",
                     out_valid, out_pkt, P1);
        end
        req_valid = 4'b0000;
        tick();
    endtask

    task automatic test_reset_mid;
        apply_reset();
        req_valid = 4'b1111;
        tick();
        tick();
        #2;
        rst_b = 1'b0;
        #1;
        total++;
        if ({out_valid, grant, out_pkt} !== {1'b0, 4'b0000, 32'h0}) begin
            bad++;
            $display("FAIL midrst got=%b/%b/%h exp=0/0000/0",
                     out_valid, grant, out_pkt);
        end
        tick();
        rst_b = 1'b1;
        #1;
        total++;
        if (grant !== 4'b0001) begin
            bad++;
            $display("FAIL midrst_first got=%b exp=0001", grant);
        end
        tick();
        total++;
        if ({out_valid, out_pkt} !== {1'b1, P0}) begin
            bad++;
            $display("FAIL midrst_out got=%b/%h exp=1/%h",
                     out_valid, out_pkt, P0);
        end
        req_valid = 4'b0000;
        tick();
    endtask

`ifdef ARB_STATS_EN
    task automatic test_stats;
        apply_reset();
        req_valid = 4'b0010;
        repeat (3) tick();
        total++;
        if (grant_count[1] !== 4'd3) begin
            bad++;
            $display("FAIL stats_mid got=%0d exp=3", grant_count[1]);
        end
        repeat (17) tick();
        req_valid = 4'b0000;
        tick();
        total++;
        if (grant_count[1] !== 4'd15) begin
            bad++;
            $display("FAIL stats_sat got=%0d exp=15", grant_count[1]);
        end
        total++;
        if ({grant_count[3], grant_count[2], grant_count[0]} !== 12'h000) begin
            bad++;
            $display("FAIL stats_other got=%h/%h/%h exp=0/0/0",
                     grant_count[3], grant_count[2], grant_count[0]);
        end
    endtask
`endif

    initial begin
        req_valid = 4'b0000;
        out_ready = 1'b1;
        rst_b     = 1'b0;
        set_pkts();
        #3;
        test_reset();
        test_single();
        test_all_four();
        test_backpressure();
        test_wrap();
        test_reset_mid();
`ifdef ARB_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
